sn74ls160_sync: RTL and testbench

- Synchronous 4-bit decade (BCD) counter, functionally modelled on the 74LS160.
- Supports synchronous parallel load, count-enable gating (ep, et) and a ripple-carry output for cascading.
- Used as a drop-in counter primitive in TTL-equivalent logic models.
- Clear is synchronous and active-high.

---
 rtl/sn74ls160_sync_pkg.sv | 31 +++
 rtl/sn74ls160_sync_if.sv | 19 +
 rtl/sn74ls160_sync_next.sv | 27 ++
 rtl/sn74ls160_sync.sv | 56 +++++
 tb/tb_sn74ls160_sync.sv | 129 ++++++++++++
 5 files changed

// File: rtl/sn74ls160_sync_pkg.sv
// sn74ls160_sync_pkg: shared width, default modulus and count-advance function.
// Honours SN74LS160_SYNC_TTL_ILLEGAL_EN for the genuine out-of-range sequence.
`default_nettype none

package sn74ls160_sync_pkg;

  localparam int WIDTH       = 4;
  localparam int MOD_DEFAULT = 10;

  // Value reached by one count step from q under modulus mod.
  function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] q, input int mod);
    logic [WIDTH-1:0] r_n;
    r_n = (int'(q) >= mod - 1) ? '0 : q + 1'b1;
`ifdef SN74LS160_SYNC_TTL_ILLEGAL_EN
    if (mod == 10 && q >= 4'd10) begin
      case (q)
        4'd10:   r_n = 4'd11;
        4'd11:   r_n = 4'd6;
        4'd12:   r_n = 4'd13;
        4'd13:   r_n = 4'd4;
        4'd14:   r_n = 4'd15;
        default: r_n = 4'd2;
      endcase
    end
`endif
    return r_n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sn74ls160_sync_if.sv
// sn74ls160_sync_if: control/data bundle of the decade counter.
`default_nettype none

interface sn74ls160_sync_if;
  import sn74ls160_sync_pkg::*;

  logic             load;
  logic             ep;
  logic             et;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             rco;

  modport master (output load, ep, et, d, input  q, rco);
  modport slave  (input  load, ep, et, d, output q, rco);

endinterface

`default_nettype wire

// File: rtl/sn74ls160_sync_next.sv
// sn74ls160_sync_next: combinational load / count / hold selection.
// Clear has priority and is applied at the register in the top level.
`default_nettype none

module sn74ls160_sync_next
  import sn74ls160_sync_pkg::*;
#(
  parameter int MOD = MOD_DEFAULT
) (
  input  wire logic             i_load_n,
  input  wire logic             i_ep,
  input  wire logic             i_et,
  input  wire logic [WIDTH-1:0] i_d,
  input  wire logic [WIDTH-1:0] i_q,
  output logic      [WIDTH-1:0] o_q_next
);

  logic w_cnt_en;

  // Ternaries rather than if/else so X on the enables propagates into q.
  assign w_cnt_en = i_ep & i_et;
  assign o_q_next = !i_load_n ? i_d
                  : (w_cnt_en ? next_count(i_q, MOD) : i_q);

endmodule

`default_nettype wire

// File: rtl/sn74ls160_sync.sv
// sn74ls160_sync: 74LS160-style synchronous BCD counter with ripple carry.
// Optional macro SN74LS160_SYNC_TTL_ILLEGAL_EN (MOD=10 only) enables TTL illegal-state sequence.
`default_nettype none

module sn74ls160_sync
  import sn74ls160_sync_pkg::*;
#(
  parameter int MOD = MOD_DEFAULT
) (
  input  wire logic       clk,
  input  wire logic       clr,
  sn74ls160_sync_if.slave bus
);

  localparam logic [WIDTH-1:0] C_TERM = WIDTH'(MOD - 1);

  generate
    if (MOD < 2 || MOD > 16) begin : g_bad_mod
      $error("sn74ls160_sync: MOD must be in 2..16");
    end
`ifdef SN74LS160_SYNC_TTL_ILLEGAL_EN
    if (MOD != 10) begin : g_bad_ttl_mod
      $error("sn74ls160_sync: TTL illegal-state sequence requires MOD=10");
    end
`endif
  endgenerate

  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_next;

  sn74ls160_sync_next #(
    .MOD (MOD)
  ) u_next (
    .i_load_n (bus.load),
    .i_ep     (bus.ep),
    .i_et     (bus.et),
    .i_d      (bus.d),
    .i_q      (r_q),
    .o_q_next (w_q_next)
  );

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q <= '0;
    end else begin
      r_q <= w_q_next;
    end
  end

  assign bus.q   = r_q;
  // Carry is gated by et only, so cascaded stages see it drop without a clock.
  assign bus.rco = bus.et & (r_q == C_TERM);

endmodule

`default_nettype wire

// File: tb/tb_sn74ls160_sync.sv
// tb_sn74ls160_sync: directed plus randomized checks against a behavioural counter model.
`default_nettype none

module tb_sn74ls160_sync;

  localparam int MOD = 10;

  logic clk;
  logic clr;
  int   n_checks;
  int   n_errors;
  int   ref_q;

  sn74ls160_sync_if bus ();

  sn74ls160_sync #(.MOD(MOD)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: one clock edge of the counter, written from the priority rules.
  function automatic int model_next(int q, logic c, logic ld_n, logic p, logic t, int dv);
    int ttl_next [10:15];
    ttl_next = '{11, 6, 13, 4, 15, 2};
    if (c) return 0;
    if (!ld_n) return dv;
    if (!(p && t)) return q;
`ifdef SN74LS160_SYNC_TTL_ILLEGAL_EN
    if (MOD == 10 && q >= 10) return ttl_next[q];
`endif
    if (q >= MOD - 1) return 0;
    return q + 1;
  endfunction

  function automatic int model_rco(int q, logic t);
    return (t && q == MOD - 1) ? 1 : 0;
  endfunction

  task automatic step(input string tag);
    @(posedge clk);
    ref_q = model_next(ref_q, clr, bus.load, bus.ep, bus.et, int'(bus.d));
    #1;
    check({tag, ".q"}, 32'(bus.q), 32'(ref_q));
    check({tag, ".rco"}, 32'(bus.rco), 32'(model_rco(ref_q, bus.et)));
  endtask

  task automatic drive(input logic c, input logic ld_n, input logic p, input logic t, input logic [3:0] dv);
    clr      = c;
    bus.load = ld_n;
    bus.ep   = p;
    bus.et   = t;
    bus.d    = dv;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    ref_q    = 0;

    // Clear with every other input undriven.
    clr = 1'b1; bus.load = 1'bx; bus.ep = 1'bx; bus.et = 1'bx; bus.d = 4'bxxxx;
    @(posedge clk); #1;
    check("clr.q", 32'(bus.q), 32'd0);
    bus.et = 1'b1; #1;
    check("clr.rco", 32'(bus.rco), 32'd0);

    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd7); step("load7");
    check("load7.exact", 32'(bus.q), 32'd7);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 4'd5); step("clr_over_load");
    check("clr_over_load.exact", 32'(bus.q), 32'd0);
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd7); step("reload7");

    // Six counts from 7 through the wrap.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    for (int i = 0; i < 6; i++) step($sformatf("count%0d", i));
    check("wrap.exact", 32'(bus.q), 32'd3);

    drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd0);
    step("inhP0"); step("inhP1");
    drive(1'b0, 1'b1, 1'b0, 1'b0, 4'd0); step("inhPT");
    drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0); step("inhT");

    // Terminal count with et low, then raise et between edges.
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd9); step("load9");
    bus.load = 1'b1; #1;
    check("tc_et0.rco", 32'(bus.rco), 32'd0);
    bus.et = 1'b1; #1;
    check("tc_et1.rco", 32'(bus.rco), 32'd1);
    bus.et = 1'b0; #1;
    check("tc_etfall.rco", 32'(bus.rco), 32'd0);

    // Out-of-range load then count.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd12); step("load12");
    drive(1'b0, 1'b1, 1'b1, 1'b1, 4'd0);
    step("oor1"); step("oor2");

    // Load wins over counting when all enables are asserted.
    drive(1'b0, 1'b0, 1'b1, 1'b1, 4'd2); step("load_over_cnt");

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 15) == 0),
            ($urandom_range(0, 4) != 0),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)));
      #1;
      check("rnd.rco_comb", 32'(bus.rco), 32'(model_rco(ref_q, bus.et)));
      step("rnd");
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
